// File: rtl/boson_frame_gate.sv
// Boson camera frame gate: finds VSYNC frame starts and passes one armed frame
// as a 16-bit valid/ready stream with last-pixel tagging and drop/geometry stats.
module boson_frame_gate #(
  parameter int FRAME_PIXELS     = 327680,
  parameter bit VSYNC_ACTIVE_LOW = 1'b1,
  parameter int CNT_W            = 20
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        arm,
  input  logic        abort,
  input  logic [15:0] s_data_i,
  input  logic        s_valid_i,
  input  logic        vsync_i,
  input  logic        hsync_i,
  output logic [15:0] m_data_o,
  output logic        m_valid_o,
  output logic        m_last_o,
  input  logic        m_ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        short_frame_o,
  output logic [15:0] ovf_cnt_o,
  output logic [11:0] line_cnt_o,
  output logic [15:0] frame_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_VS, S_CAPTURE, S_DRAIN} state_t;

  localparam logic             VS_IDLE  = VSYNC_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] LP_FRAME = CNT_W'(FRAME_PIXELS);

  state_t           r_state;
  logic             r_vs_q;
  logic             r_hs_q;
  logic [CNT_W-1:0] r_pix_cnt;
  logic [11:0]      r_line_run;

  logic             w_fs;
  logic             w_hs_rise;
  logic             w_cap;
  logic             w_accept;
  logic             w_drop;
  logic [CNT_W-1:0] w_pix_nxt;
  logic             w_is_last;

  assign w_fs      = (vsync_i != VS_IDLE) & (r_vs_q == VS_IDLE);
  assign w_hs_rise = hsync_i & ~r_hs_q;
  assign w_cap     = (r_state == S_CAPTURE);
  // A frame start in CAPTURE ends the frame; that cycle's pixel is neither
  // accepted nor counted as an overflow.
  assign w_accept  = w_cap & s_valid_i & ~w_fs & (~m_valid_o | m_ready_i);
  assign w_drop    = w_cap & s_valid_i & ~w_fs & m_valid_o & ~m_ready_i;
  assign w_pix_nxt = r_pix_cnt + 1'b1;
  assign w_is_last = (w_pix_nxt == LP_FRAME);

  assign busy_o = (r_state == S_WAIT_VS) | (r_state == S_CAPTURE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_vs_q        <= VS_IDLE;
      r_hs_q        <= 1'b0;
      r_pix_cnt     <= '0;
      r_line_run    <= '0;
      m_data_o      <= '0;
      m_valid_o     <= 1'b0;
      m_last_o      <= 1'b0;
      done_o        <= 1'b0;
      short_frame_o <= 1'b0;
      ovf_cnt_o     <= '0;
      line_cnt_o    <= '0;
      frame_cnt_o   <= '0;
    end else begin
      r_vs_q <= vsync_i;
      r_hs_q <= hsync_i;
      done_o <= 1'b0;
      if (w_fs) frame_cnt_o <= frame_cnt_o + 1'b1;
      if (m_valid_o && m_ready_i) m_valid_o <= 1'b0;

      if (abort) begin
        r_state   <= S_IDLE;
        m_valid_o <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: if (arm) begin
            r_state       <= S_WAIT_VS;
            ovf_cnt_o     <= '0;
            short_frame_o <= 1'b0;
            r_pix_cnt     <= '0;
            r_line_run    <= '0;
          end
          S_WAIT_VS: if (w_fs) r_state <= S_CAPTURE;
          S_CAPTURE: begin
            if (w_fs) begin
              short_frame_o <= 1'b1;
              done_o        <= 1'b1;
              line_cnt_o    <= r_line_run;
              r_state       <= S_IDLE;
            end else begin
              if (w_hs_rise && r_line_run != 12'hFFF) r_line_run <= r_line_run + 1'b1;
              if (w_accept) begin
                m_valid_o <= 1'b1;
                m_data_o  <= s_data_i;
                m_last_o  <= w_is_last;
                r_pix_cnt <= w_pix_nxt;
                if (w_is_last) r_state <= S_DRAIN;
              end
              if (w_drop && ovf_cnt_o != 16'hFFFF) ovf_cnt_o <= ovf_cnt_o + 1'b1;
            end
          end
          S_DRAIN: if (!m_valid_o || m_ready_i) begin
            done_o     <= 1'b1;
            line_cnt_o <= r_line_run;
            r_state    <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boson_frame_gate.sv
// Directed bench for boson_frame_gate with a 16-pixel frame; instance b covers
// the active-high VSYNC build and asynchronous reset.
module tb_boson_frame_gate;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        arm = 1'b0, abort = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0, vsync = 1'b1, hsync = 1'b0, m_ready = 1'b1;
  logic [15:0] m_data, ovf_cnt, frame_cnt;
  logic        m_valid, m_last, busy, done, short_frame;
  logic [11:0] line_cnt;

  logic        b_arm = 1'b0, b_vsync = 1'b0, b_valid = 1'b0;
  logic [15:0] b_data = '0;
  logic [15:0] b_m_data, b_ovf, b_frame_cnt;
  logic        b_m_valid, b_m_last, b_busy, b_done, b_short;
  logic [11:0] b_line_cnt;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  boson_frame_gate #(.FRAME_PIXELS(16), .VSYNC_ACTIVE_LOW(1'b1), .CNT_W(20)) dut (
    .clk(clk), .resetn(resetn), .arm(arm), .abort(abort),
    .s_data_i(s_data), .s_valid_i(s_valid), .vsync_i(vsync), .hsync_i(hsync),
    .m_data_o(m_data), .m_valid_o(m_valid), .m_last_o(m_last), .m_ready_i(m_ready),
    .busy_o(busy), .done_o(done), .short_frame_o(short_frame), .ovf_cnt_o(ovf_cnt),
    .line_cnt_o(line_cnt), .frame_cnt_o(frame_cnt));

  boson_frame_gate #(.FRAME_PIXELS(16), .VSYNC_ACTIVE_LOW(1'b0), .CNT_W(20)) dut_b (
    .clk(clk), .resetn(resetn), .arm(b_arm), .abort(1'b0),
    .s_data_i(b_data), .s_valid_i(b_valid), .vsync_i(b_vsync), .hsync_i(1'b0),
    .m_data_o(b_m_data), .m_valid_o(b_m_valid), .m_last_o(b_m_last), .m_ready_i(1'b1),
    .busy_o(b_busy), .done_o(b_done), .short_frame_o(b_short), .ovf_cnt_o(b_ovf),
    .line_cnt_o(b_line_cnt), .frame_cnt_o(b_frame_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic frame_start();
    vsync = 1'b0; tick(); vsync = 1'b1;
  endtask

  int lasts;

  initial begin
    #12 resetn = 1'b1;
    tick();
    chk("rst_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame", frame_cnt, 0);
    chk("rst_ovf", ovf_cnt, 0);
    chk("rst_line", line_cnt, 0);
    chk("rst_done", done, 0);

    // Unarmed frame still counts
    frame_start();
    chk("unarmed_fcnt", frame_cnt, 1);
    chk("unarmed_busy", busy, 0);

    // Armed: pixels before fs are ignored
    do_arm();
    chk("arm_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 16'hBAD0 + 16'(i); tick();
      chk("pre_fs_valid", m_valid, 0);
    end
    frame_start();  // pixel coincident with fs is ignored too
    chk("fs_valid", m_valid, 0);
    chk("fs_fcnt", frame_cnt, 2);

    // Full 16-pixel frame, 4 lines x 4 pixels
    for (int n = 0; n < 16; n++) begin
      s_valid = 1'b1; s_data = 16'h0100 + 16'(n); hsync = (n % 4 == 0); tick();
      chk("beat_valid", m_valid, 1);
      chk("beat_data", m_data, 32'h0100 + n);
      chk("beat_last", m_last, (n == 15));
    end
    s_valid = 1'b0; hsync = 1'b0; tick();
    chk("full_done", done, 1);
    chk("full_valid", m_valid, 0);
    chk("full_lines", line_cnt, 4);
    chk("full_ovf", ovf_cnt, 0);
    chk("full_busy", busy, 0);
    tick();
    chk("done_pulse", done, 0);

    // Back-pressure: first pixel held, 4 stalled pixels dropped
    do_arm();
    frame_start();
    chk("bp_fcnt", frame_cnt, 3);
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 16'hA000 + 16'(i); tick();
      chk("bp_hold", m_data, 32'hA000);
    end
    chk("bp_ovf", ovf_cnt, 4);
    m_ready = 1'b1; s_data = 16'hA005; tick();
    chk("bp_next", m_data, 32'hA005);
    chk("bp_ovf2", ovf_cnt, 4);

    // Abort while holding a beat
    m_ready = 1'b0; s_valid = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_valid", m_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ovf_kept", ovf_cnt, 4);
    m_ready = 1'b1;

    // Short frame: second fs after 10 pixels
    do_arm();
    chk("rearm_ovf", ovf_cnt, 0);
    frame_start();
    lasts = 0;
    for (int n = 0; n < 10; n++) begin
      s_valid = 1'b1; s_data = 16'h0200 + 16'(n); hsync = (n % 4 == 0); tick();
      if (m_last) lasts++;
    end
    chk("short_nolast", lasts, 0);
    s_valid = 1'b0; hsync = 1'b0;
    frame_start();
    chk("short_done", done, 1);
    chk("short_flag", short_frame, 1);
    chk("short_busy", busy, 0);
    chk("short_lines", line_cnt, 3);
    chk("short_fcnt", frame_cnt, 5);
    tick();
    chk("short_sticky", short_frame, 1);
    do_arm();
    chk("arm_clr_short", short_frame, 0);
    abort = 1'b1; tick(); abort = 1'b0;

    // Active-high VSYNC build
    b_arm = 1'b1; tick(); b_arm = 1'b0;
    b_vsync = 1'b1; tick();
    chk("b_fcnt", b_frame_cnt, 1);
    chk("b_busy", b_busy, 1);
    b_valid = 1'b1; b_data = 16'h5A5A; tick();
    chk("b_valid", b_m_valid, 1);
    chk("b_data", b_m_data, 32'h5A5A);

    // Asynchronous reset mid-frame
    #2 resetn = 1'b0;
    #1;
    chk("arst_valid", b_m_valid, 0);
    chk("arst_busy", b_busy, 0);
    chk("arst_fcnt", b_frame_cnt, 0);
    chk("arst_a_fcnt", frame_cnt, 0);
    b_valid = 1'b0;
    #10 resetn = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/boson_frame_gate.md
Name: boson_frame_gate

Overview:
- Sits between the Boson CMOS input buffers and the 16→32 stream upsizer, in the camera clock domain.
- Finds frame boundaries from VSYNC and passes exactly one armed frame of 16-bit pixels as a valid/ready stream.
- Flags the last pixel of the frame and counts line/pixel geometry.
- Reports frame completion, short frames and overflow drops to firmware (via a CSR bridge in the wb domain).

Parameters:
- FRAME_PIXELS, 327680, expected pixels per frame (640x512); sets m_last and the frame-done point.
- VSYNC_ACTIVE_LOW, 1, 1: VSYNC asserted when low; 0: asserted when high.
- CNT_W, 20, width of the pixel counter; must satisfy 2^CNT_W > FRAME_PIXELS.

Ports:
- clk  in  1  camera pixel clock (BOSON_CLK).
- resetn  in  1  asynchronous active-low reset.
- arm  in  1  one-cycle pulse: capture the next complete frame.
- abort  in  1  one-cycle pulse: return to IDLE, discard pending output.
- s_data_i  in  16  pixel data.
- s_valid_i  in  1  pixel valid (BOSON_VALID); no back-pressure is possible upstream.
- vsync_i  in  1  frame sync.
- hsync_i  in  1  line sync, active high.
- m_data_o  out  16  pixel to upsizer.
- m_valid_o  out  1  output stage holds a pixel.
- m_last_o  out  1  qualifies the final pixel of the frame.
- m_ready_i  in  1  upsizer ready.
- busy_o  out  1  state is WAIT_VS or CAPTURE.
- done_o  out  1  one-cycle pulse when the frame ends, normal or short.
- short_frame_o  out  1  sticky: the last frame ended early on VSYNC.
- ovf_cnt_o  out  16  saturating count of dropped pixels; cleared on arm.
- line_cnt_o  out  12  HSYNC rising edges seen in the last captured frame.
- frame_cnt_o  out  16  wrapping count of VSYNC frame starts seen since reset, armed or not.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counters 0; vs_q = deasserted level.
- Frame start (fs):
  - Registered previous VSYNC vs_q.
  - fs = 1 in the cycle VSYNC transitions from deasserted to asserted (polarity per VSYNC_ACTIVE_LOW).
  - frame_cnt_o increments on every fs.
- States:
  - IDLE: arm → WAIT_VS; clears ovf_cnt, short_frame, pix_cnt and line_cnt.
  - WAIT_VS: fs → CAPTURE. Pixels arriving before fs are ignored; this is not a drop.
  - CAPTURE:
    - Accepted pixels increment pix_cnt.
    - The pixel making pix_cnt == FRAME_PIXELS is tagged last.
    - Once that pixel is loaded into the output stage → DRAIN.
    - fs before the count completes: short_frame_o = 1, done_o pulse, → IDLE. The partial frame already accepted is not retracted; no m_last is emitted.
  - DRAIN: wait until the output stage is empty, i.e. the last beat has handshaken. Then done_o pulses for 1 cycle and line_cnt_o is latched → IDLE.
- Pixel acceptance: in CAPTURE, s_valid_i=1 and the stage is empty or handshaking this cycle (m_valid_o & m_ready_i).
  - Load m_data_o = s_data_i; m_last_o = (pix_cnt+1 == FRAME_PIXELS).
  - Latency is one clock from input to m_valid_o.
- Drop: in CAPTURE, s_valid_i=1 and the stage is full and not handshaking.
  - The pixel is discarded and ovf_cnt increments, saturating at 0xFFFF.
  - pix_cnt is not incremented.
- Output stream rules:
  - m_valid_o stays high until m_ready_i; m_data_o and m_last_o are stable while m_valid_o & !m_ready_i.
  - Handshake without a new load clears m_valid_o.
- Lines: a running counter increments on hsync rising edge in CAPTURE, saturating at 4095. It is copied to line_cnt_o on done_o (both end paths).
- arm while not IDLE: ignored.
- abort in any state: → IDLE next cycle; m_valid_o cleared; no done_o; counters retain values. abort and arm in the same cycle: abort wins.
- fs coincident with an accepted pixel in WAIT_VS: the pixel is ignored; capture starts the next cycle.
- fs coincident with pixel acceptance in CAPTURE: short-frame termination takes priority and that pixel is dropped without counting as overflow.
- Async reset mid-frame: everything returns to reset values immediately; the downstream sees m_valid_o fall.

Test Plan:
- FRAME_PIXELS=16, m_ready_i=1, 4 lines × 4 pixels after arm and fs → 16 beats in order, m_last_o only on beat 16, done_o 1 cycle after that handshake, line_cnt_o=4, ovf=0.
- Valid pixels before the first fs after arm → no m_valid_o until fs; frame_cnt_o increments on every fs, including unarmed frames.
- m_ready_i held low for 5 cycles with s_valid_i continuously high in CAPTURE → first pixel held stable, ovf_cnt_o=4 (pixels arriving on the 4 stalled cycles after the stage fills are dropped), those pixels are absent from the output.
- Second fs after 10 of 16 pixels → short_frame_o=1, done_o pulse, no m_last_o, state IDLE; the next arm clears short_frame_o.
- abort mid-CAPTURE while m_valid_o=1 → m_valid_o=0 next cycle, busy_o=0, no done_o.
- VSYNC_ACTIVE_LOW=0 build with a high-going VSYNC → capture starts on the rising edge; resetn pulse mid-frame → all outputs 0 asynchronously.
